wb_stage_hs: RTL and testbench
==============================

// Module: wb_stage_hs
// PURPOSE
//  Parametrised write-back stage with a valid/ready handshake. Sits between the MEM stage
//  and the register file. Captures one instruction per accepted transfer and selects the
//  write-back value (ALU result, load data or V^N flag). Stalls on loads until the data
//  memory answers, with a timeout. Drives the register-file write port (BUS_D, DA_out, RW_out).
// PARAMETERS
//  DATA_W       32  datapath width (>=2)
//  REG_AW       5   register address width
//  MEM_TIMEOUT  15  max falling edges spent waiting for mem_rsp_valid (1..2^8-1)
// PORTS
//  CLOCK          in   1       stage clock; all state updates on the falling edge
//  RESET          in   1       asynchronous, active-low reset
//  in_valid       in   1       MEM stage presents an instruction
//  in_ready       out  1       stage can accept this edge
//  RW             in   1       register write enable
//  DA             in   REG_AW  destination register
//  MD             in   2       0=F, 1=Data (load), 2=V^N flag, 3=reserved
//  VxorN          in   1       overflow^negative flag
//  F              in   DATA_W  ALU/function-unit result
//  mem_rsp_valid  in   1       Data is valid this edge
//  Data           in   DATA_W  load data from data memory
//  BUS_D          out  DATA_W  write-back value
//  RW_out         out  1       register-file write strobe
//  DA_out         out  REG_AW  register-file write address
//  wb_busy        out  1       load outstanding (state WAIT_MEM)
//  wb_err         out  1       sticky: timeout or MD=3 seen
// BEHAVIOUR
//  - Reset (RESET=0, async): state=IDLE, all registers 0. BUS_D=0, RW_out=0, DA_out=0,
//    wb_busy=0, wb_err=0. Reset mid-load drops the load; no write is issued.
//  - States: IDLE (no entry), WAIT_MEM (load captured, no data), RETIRE (result valid,
//    one cycle).
//  - in_ready = (state != WAIT_MEM). Transfer = in_valid & in_ready at a falling edge.
//    The transfer registers RW, DA, MD, VxorN and F. VxorN is registered, never used live.
//  - Transfer with MD!=1 -> RETIRE. Transfer with MD=1 -> WAIT_MEM, timeout counter=0.
//  - WAIT_MEM:
//      mem_rsp_valid=1 -> latch Data, go to RETIRE.
//      Otherwise counter+1; if counter reaches MEM_TIMEOUT -> set wb_err, write
//      suppressed, go to IDLE.
//    mem_rsp_valid is ignored in every other state, including the transfer edge.
//    Minimum load latency is two falling edges.
//  - RETIRE:
//      Transfer on the same edge -> accept (back-to-back, one instruction per cycle).
//      No transfer -> IDLE.
//  - BUS_D (combinational from registered state, defined in every state, no latch):
//      MD=0 -> F_q
//      MD=1 -> Data_q
//      MD=2 -> {(DATA_W-1)'b0, VxorN_q}
//      MD=3 -> 0
//    In IDLE/WAIT_MEM, BUS_D holds its last value (registered, not re-evaluated).
//  - RW_out = (state==RETIRE) & RW_q & (DA_q != 0) & (MD_q != 3). R0 is never written.
//  - MD=3 with RW=1: set wb_err, retire without a write.
//  - wb_err is cleared only by reset.
//  - wb_busy = (state==WAIT_MEM).
// STRUCTURE
//  - Shared package cpu_pkg: MD encodings (MD_F, MD_DATA, MD_VN, MD_RSVD), state typedef
//    wb_state_t, REG_AW default.
//  - Sub-module wb_mux: combinational BUS_D select, parametrised by DATA_W. It is reused
//    by the forwarding path.
//  - FSM, capture registers and timeout counter stay in this module.
// TESTING
//  1. RESET low mid-WAIT_MEM -> all outputs 0 asynchronously. After release, no write
//     for the dropped load.
//  2. Back-to-back MD=0, F=0x12345678, DA=3, RW=1, then F=0xCAFEF00D, DA=4 -> two
//     consecutive RW_out pulses with those values; in_ready stays 1.
//  3. MD=1 load to DA=7, mem_rsp_valid after 3 edges with Data=0xDEADBEEF
//     -> in_ready=0 and wb_busy=1 for 3 edges, then one write of 0xDEADBEEF to R7.
//  4. MD=1 with no response -> after 15 edges wb_err=1, no write, in_ready=1, state IDLE.
//  5. MD=2, VxorN=1, DA=0, RW=1 -> no write (R0). Same with DA=5 -> BUS_D=0x00000001.
//     VxorN toggled after capture does not change BUS_D.
//  6. MD=3, RW=1 -> RW_out=0, BUS_D=0, wb_err=1 and stays set.
//     Repeat with DATA_W=16, REG_AW=4.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-back select encodings, write-back FSM states and
// default register-address width.
package cpu_pkg;

  localparam int unsigned REG_AW_DEFAULT = 5;

  localparam logic [1:0] MD_F    = 2'd0;
  localparam logic [1:0] MD_DATA = 2'd1;
  localparam logic [1:0] MD_VN   = 2'd2;
  localparam logic [1:0] MD_RSVD = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StWaitMem,
    StRetire
  } wb_state_t;

endpackage

// File: rtl/wb_mux.sv
// Write-back value select: ALU result, load data or the V^N flag.
// Purely combinational so the forwarding path can reuse it.
module wb_mux
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        md,
  input  logic [DATA_W-1:0] f,
  input  logic [DATA_W-1:0] data,
  input  logic              vxorn,
  output logic [DATA_W-1:0] bus
);

  always_comb begin
    bus = '0;
    case (md)
      MD_F:    bus = f;
      MD_DATA: bus = data;
      MD_VN:   bus = {{(DATA_W-1){1'b0}}, vxorn};
      default: bus = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage_hs.sv
// Write-back stage with valid/ready handshake: captures one instruction per transfer,
// waits (with timeout) for load data and drives the register-file write port.
module wb_stage_hs
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_AW      = REG_AW_DEFAULT,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RW,
  input  logic [REG_AW-1:0] DA,
  input  logic [1:0]        MD,
  input  logic              VxorN,
  input  logic [DATA_W-1:0] F,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] Data,
  output logic [DATA_W-1:0] BUS_D,
  output logic              RW_out,
  output logic [REG_AW-1:0] DA_out,
  output logic              wb_busy,
  output logic              wb_err
);

  localparam int unsigned CntW = 8;

  wb_state_t         state_q, state_d;
  logic              rw_q;
  logic [REG_AW-1:0] da_q;
  logic [1:0]        md_q;
  logic              vxn_q;
  logic [DATA_W-1:0] f_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] bus_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              transfer;
  logic              data_en;
  logic [DATA_W-1:0] mux_out;

  assign transfer = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    data_en = 1'b0;
    case (state_q)
      StWaitMem: begin
        if (mem_rsp_valid) begin
          data_en = 1'b1;
          state_d = StRetire;
        end else if (cnt_q == CntW'(MEM_TIMEOUT - 1)) begin
          // Give up on the load: flag it and drop the write.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        if (transfer) begin
          cnt_d   = '0;
          state_d = (MD == MD_DATA) ? StWaitMem : StRetire;
          if (MD == MD_RSVD) err_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(negedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rw_q    <= 1'b0;
      da_q    <= '0;
      md_q    <= '0;
      vxn_q   <= 1'b0;
      f_q     <= '0;
      data_q  <= '0;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (transfer) begin
        rw_q  <= RW;
        da_q  <= DA;
        md_q  <= MD;
        vxn_q <= VxorN;
        f_q   <= F;
      end
      if (data_en) data_q <= Data;
      // Hold the retired value so BUS_D stays stable while idle or waiting.
      if (state_q == StRetire) bus_q <= mux_out;
    end
  end

  wb_mux #(
    .DATA_W(DATA_W)
  ) u_wb_mux (
    .md   (md_q),
    .f    (f_q),
    .data (data_q),
    .vxorn(vxn_q),
    .bus  (mux_out)
  );

  assign in_ready = (state_q != StWaitMem);
  assign wb_busy  = (state_q == StWaitMem);
  assign wb_err   = err_q;
  assign DA_out   = da_q;
  assign BUS_D    = (state_q == StRetire) ? mux_out : bus_q;
  assign RW_out   = (state_q == StRetire) & rw_q & (da_q != '0) & (md_q != MD_RSVD);

endmodule

// File: tb/tb_wb_stage_hs.sv
// Self-checking bench for wb_stage_hs: directed table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_wb_stage_hs;

  localparam int TO = 15;

  logic        clk = 1'b1;
  logic        rst_n;
  logic        in_valid, rw, vxn, rsp;
  logic [4:0]  da;
  logic [1:0]  md;
  logic [31:0] f, data;
  logic        in_ready, rw_out, wb_busy, wb_err;
  logic [31:0] bus_d;
  logic [4:0]  da_out;

  logic        s_in_ready, s_rw_out, s_wb_busy, s_wb_err;
  logic [15:0] s_bus_d;
  logic [3:0]  s_da_out;
  logic [3:0]  s_da;
  logic [15:0] s_f, s_data;

  assign s_da   = da[3:0];
  assign s_f    = f[15:0];
  assign s_data = data[15:0];

  always #5 clk = ~clk;

  wb_stage_hs #(.DATA_W(32), .REG_AW(5), .MEM_TIMEOUT(TO)) dut (
    .CLOCK(clk), .RESET(rst_n), .in_valid(in_valid), .in_ready(in_ready), .RW(rw),
    .DA(da), .MD(md), .VxorN(vxn), .F(f), .mem_rsp_valid(rsp), .Data(data),
    .BUS_D(bus_d), .RW_out(rw_out), .DA_out(da_out), .wb_busy(wb_busy), .wb_err(wb_err)
  );

  wb_stage_hs #(.DATA_W(16), .REG_AW(4), .MEM_TIMEOUT(TO)) dut_s (
    .CLOCK(clk), .RESET(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .RW(rw),
    .DA(s_da), .MD(md), .VxorN(vxn), .F(s_f), .mem_rsp_valid(rsp), .Data(s_data),
    .BUS_D(s_bus_d), .RW_out(s_rw_out), .DA_out(s_da_out), .wb_busy(s_wb_busy),
    .wb_err(s_wb_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; rw = 0; da = 0; md = 0; vxn = 0; f = 0; rsp = 0; data = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #2 rst_n = 1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic [1:0] m,
                       input logic x, input logic [31:0] fv);
    in_valid = v; rw = w; da = a; md = m; vxn = x; f = fv;
  endtask

  // Reference model: tracks the in-flight instruction, not the RTL's state register.
  bit          m_busy, m_ret, m_we, m_err;
  int          m_wait;
  logic [31:0] m_val, m_last;
  logic [4:0]  m_da;

  task automatic model_reset();
    m_busy = 0; m_ret = 0; m_we = 0; m_err = 0; m_wait = 0;
    m_val = 0; m_last = 0; m_da = 0;
  endtask

  task automatic model_edge();
    if (m_busy) begin
      if (rsp) begin
        m_busy = 0; m_ret = 1; m_val = data;
      end else begin
        m_wait++;
        if (m_wait == TO) begin m_busy = 0; m_err = 1; end
      end
    end else begin
      if (m_ret) m_last = m_val;
      m_ret = 0;
      if (in_valid) begin
        m_da = da;
        m_we = rw && (da != 0) && (md != 3);
        if (md == 3) m_err = 1;
        if (md == 0) m_val = f;
        else if (md == 2) m_val = {31'b0, vxn};
        else if (md == 3) m_val = 0;
        if (md == 1) begin m_busy = 1; m_wait = 0; end
        else m_ret = 1;
      end
    end
  endtask

  function automatic logic [63:0] pack(input logic rdy, input logic bsy, input logic wo,
                                       input logic er, input logic [4:0] a,
                                       input logic [31:0] b);
    return {23'b0, rdy, bsy, wo, er, a, b};
  endfunction

  typedef struct {
    logic        v, w, x, r;
    logic [4:0]  a;
    logic [1:0]  m;
    logic [31:0] fv, dv;
    logic        e_rdy, e_bsy, e_wo, e_er;
    logic [4:0]  e_a;
    logic [31:0] e_b;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic v, input logic w, input logic [4:0] a,
                              input logic [1:0] m, input logic x, input logic [31:0] fv,
                              input logic r, input logic [31:0] dv, input logic e_rdy,
                              input logic e_bsy, input logic e_wo, input logic [31:0] e_b,
                              input logic [4:0] e_a, input logic e_er);
    vec_t t;
    t.v = v; t.w = w; t.a = a; t.m = m; t.x = x; t.fv = fv; t.r = r; t.dv = dv;
    t.e_rdy = e_rdy; t.e_bsy = e_bsy; t.e_wo = e_wo; t.e_b = e_b; t.e_a = e_a; t.e_er = e_er;
    return t;
  endfunction

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();

    //          v  w  da  md x  F             rsp Data          rdy bsy wo BUS_D        DA err
    tbl[0]  = mk(1, 1, 3,  0, 0, 32'h12345678, 0, 32'h0,        1,  0,  1, 32'h12345678, 3, 0);
    tbl[1]  = mk(1, 1, 4,  0, 0, 32'hCAFEF00D, 0, 32'h0,        1,  0,  1, 32'hCAFEF00D, 4, 0);
    tbl[2]  = mk(0, 0, 0,  0, 0, 32'h0,        0, 32'h0,        1,  0,  0, 32'hCAFEF00D, 4, 0);
    tbl[3]  = mk(1, 1, 7,  1, 0, 32'h0,        1, 32'h11111111, 0,  1,  0, 32'hCAFEF00D, 7, 0);
    tbl[4]  = mk(1, 1, 9,  0, 0, 32'h5,        0, 32'h0,        0,  1,  0, 32'hCAFEF00D, 7, 0);
    tbl[5]  = mk(0, 0, 0,  0, 0, 32'h0,        0, 32'h0,        0,  1,  0, 32'hCAFEF00D, 7, 0);
    tbl[6]  = mk(0, 0, 0,  0, 0, 32'h0,        1, 32'hDEADBEEF, 1,  0,  1, 32'hDEADBEEF, 7, 0);
    tbl[7]  = mk(0, 0, 0,  0, 0, 32'h0,        0, 32'h0,        1,  0,  0, 32'hDEADBEEF, 7, 0);
    tbl[8]  = mk(1, 1, 0,  2, 1, 32'hFFFF,     0, 32'h0,        1,  0,  0, 32'h00000001, 0, 0);
    tbl[9]  = mk(1, 1, 5,  2, 1, 32'hFFFF,     0, 32'h0,        1,  0,  1, 32'h00000001, 5, 0);
    tbl[10] = mk(0, 0, 0,  0, 0, 32'h0,        0, 32'h0,        1,  0,  0, 32'h00000001, 5, 0);

    // Reset state
    step();
    check("reset_outputs", pack(in_ready, wb_busy, rw_out, wb_err, da_out, bus_d),
          pack(1, 0, 0, 0, 0, 0));
    rst_n = 1;

    // Directed table: back-to-back, load with latency 3, V^N flag and R0
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].m, tbl[i].x, tbl[i].fv);
      rsp = tbl[i].r; data = tbl[i].dv;
      step();
      check($sformatf("table_row%0d", i),
            pack(in_ready, wb_busy, rw_out, wb_err, da_out, bus_d),
            pack(tbl[i].e_rdy, tbl[i].e_bsy, tbl[i].e_wo, tbl[i].e_er, tbl[i].e_a, tbl[i].e_b));
    end

    // VxorN changed after capture must not reach BUS_D
    drive(1, 1, 5, 2, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("vxn_live_retire", {63'b0, rw_out, bus_d}, {63'b0, 1'b1, 32'h1});
    step();
    check("vxn_live_idle", {32'b0, bus_d}, 64'h1);

    // Load timeout
    drive(1, 1, 6, 1, 0, 0);
    rsp = 0;
    step();
    in_valid = 0;
    for (int i = 1; i < TO; i++) step();
    check("timeout_still_waiting", {60'b0, in_ready, wb_busy, wb_err, rw_out}, 64'b0100);
    step();
    check("timeout_expired", {60'b0, in_ready, wb_busy, wb_err, rw_out}, 64'b1010);
    step();
    check("timeout_no_late_write", {62'b0, wb_err, rw_out}, 64'b10);

    // Reset mid-load
    drive(1, 1, 7, 1, 0, 0);
    step();
    in_valid = 0;
    step();
    check("pre_reset_busy", {63'b0, wb_busy}, 64'h1);
    #2 rst_n = 0;
    #1;
    check("async_reset_outputs", pack(in_ready, wb_busy, rw_out, wb_err, da_out, bus_d),
          pack(1, 0, 0, 0, 0, 0));
    #1 rst_n = 1;
    rsp = 1; data = 32'hDEADBEEF;
    step();
    check("dropped_load_edge1", {31'b0, rw_out, bus_d}, 64'h0);
    rsp = 0;
    step();
    check("dropped_load_edge2", {62'b0, rw_out, wb_busy}, 64'h0);

    // Reserved MD on both widths
    do_reset();
    drive(1, 1, 5, 3, 1, 32'hFFFFFFFF);
    step();
    check("rsvd_w32", {30'b0, rw_out, wb_err, bus_d}, {30'b0, 1'b0, 1'b1, 32'h0});
    check("rsvd_w16", {46'b0, s_rw_out, s_wb_err, s_bus_d}, {46'b0, 1'b0, 1'b1, 16'h0});
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    check("rsvd_sticky", {62'b0, wb_err, s_wb_err}, 64'b11);
    drive(1, 1, 4, 0, 0, 32'hCAFEF00D);
    step();
    check("w16_alu", {43'b0, s_rw_out, s_wb_err, s_da_out, s_bus_d},
          {43'b0, 1'b1, 1'b1, 4'd4, 16'hF00D});
    drive(1, 1, 9, 2, 1, 0);
    step();
    check("w16_vn", {47'b0, s_rw_out, s_bus_d}, {47'b0, 1'b1, 16'h0001});
    drive(0, 0, 0, 0, 0, 0);
    step();

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      int r;
      if (i % 500 == 499) begin
        do_reset();
        model_reset();
      end
      r = int'($urandom_range(15, 0));
      md = (r < 6) ? 2'd0 : (r < 11) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      in_valid = ($urandom_range(3, 0) != 0);
      rw = (md == 3) ? 1'b1 : ($urandom_range(3, 0) != 0);
      da = 5'($urandom());
      vxn = 1'($urandom());
      f = $urandom();
      data = $urandom();
      rsp = (i % 500 < 250) ? ($urandom_range(2, 0) == 0) : ($urandom_range(7, 0) == 0);
      model_edge();
      step();
      check($sformatf("random_cycle%0d", i),
            pack(in_ready, wb_busy, rw_out, wb_err, da_out, bus_d),
            pack(!m_busy, m_busy, m_ret && m_we, m_err, m_da, m_ret ? m_val : m_last));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
